mul_acc_arbiter: RTL
====================

Name: mul_acc_arbiter

Overview:
- Shares one sequential multiply-accumulate unit between two requesters. Each requester is a PID-style core with its own start/done strobe handshake.
- Sits between the requester cores and the shared MUL_ACC instance. This lets a second control loop (e.g. second fan) reuse the multiplier instead of instantiating another.
- Each requester sees a private, registered result. Interleaved accumulation chains therefore stay independent.

Parameters:
- N, 41, operand width of shared multiplier (REG_BITWIDTH + ADC_BITWIDTH + 1); a/b/acc/out buses are 2*N wide.
- TIMEOUT_CYCLES, 4095, maximum clk_i cycles from mul_start_strb_o to mul_done_strb_i before abort; counter width = $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- req_start_strb_i  in  2  per-requester one-cycle start pulse; bit k = requester k
- req0_a_i, req0_b_i, req0_acc_i  in  2N each  requester 0 operands (sampled on its start pulse)
- req1_a_i, req1_b_i, req1_acc_i  in  2N each  requester 1 operands
- req_done_strb_o  out  2  per-requester one-cycle completion pulse
- req0_out_o, req1_out_o  out  2N each  per-requester held result a*b+acc
- mul_start_strb_o  out  1  start pulse to shared multiplier
- mul_a_o, mul_b_o, mul_acc_o  out  2N each  registered operands to shared multiplier
- mul_done_strb_i  in  1  multiplier completion pulse
- mul_out_i  in  2N  multiplier result, valid with mul_done_strb_i
- busy_o  out  1  high while an operation is in flight
- overrun_o  out  1  sticky: start pulse received while that requester already pending/in flight
- timeout_o  out  1  sticky: multiplier failed to answer within TIMEOUT_CYCLES

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - req_done_strb_o=0, req*_out_o=0, mul_start_strb_o=0, mul_*_o=0.
  - busy_o=0, overrun_o=0, timeout_o=0.
  - Pending flags cleared, RR pointer favours requester 0, state IDLE.
- Request capture:
  - On req_start_strb_i[k], if requester k is neither pending nor in flight: latch its a/b/acc into holding regs k and set pending[k].
  - Otherwise set overrun_o, drop the pulse, leave the holding regs untouched.
  - A start pulse in the same cycle as mul_done_strb_i for owner k is accepted (k is no longer in flight).
- FSM states: IDLE, BUSY.
  - IDLE with any pending:
    - Grant per round-robin: if both pending, grant the one not granted last.
    - Register holding regs of the winner onto mul_a/b/acc_o.
    - Assert mul_start_strb_o for exactly the next cycle; clear pending[winner]; owner<=winner; busy_o<=1; timeout counter<=0; go BUSY.
  - BUSY:
    - mul_*_o held stable; counter increments.
    - On mul_done_strb_i: req{owner}_out_o<=mul_out_i and req_done_strb_o[owner]=1 for one cycle (next cycle); busy_o<=0; go IDLE.
    - If counter reaches TIMEOUT_CYCLES first: set timeout_o; pulse req_done_strb_o[owner] with out unchanged; go IDLE.
- Latency:
  - Start pulse at cycle t with arbiter idle -> pending at t+1 -> mul_start_strb_o at t+2.
  - mul_done at d -> req_done/out at d+1.
  - Earliest next mul_start_strb_o is d+2.
- mul_done_strb_i in IDLE is ignored (late answer after timeout).
- Pulses on req_start_strb_i both bits same cycle: both captured; RR decides order.
- Requester results are never overwritten by the other requester's operations. Each core may use its own out_o as the next acc_i.
- Reset mid-operation: everything returns to reset values in one cycle. The shared multiplier shares rst_i.
- Sticky flags clear only by reset.

Decomposition:
- Shared package: FSM state encoding (IDLE/BUSY), NUM_REQ=2, default N and TIMEOUT_CYCLES.
- Sub-module rr_arbiter_2: combinational grant from pending[1:0] and last-grant pointer, plus registered pointer update on grant.
- Holding regs, FSM and timeout counter stay in mul_acc_arbiter.

Test Plan:
1. Single request: req0 a=3, b=5, acc=7 strobed at t; model replies 16 cycles after start -> mul_start at t+2, req_done_strb_o[0] one cycle after mul_done, req0_out_o=22, req1_out_o=0.
2. Simultaneous: both strobed same cycle, req0 (2,4,0), req1 (-3,6,10) -> req0 served first, then req1; outputs 8 and -8; next simultaneous pair serves req1 first.
3. Interleaved chains: each core runs a 5-step accumulate using its own out_o as acc -> final results match independent golden sums, with no cross-contamination.
4. Overrun: second req0 strobe while req0 in flight -> overrun_o=1, only one done pulse, req0_out_o equals first operation's result.
5. Timeout: model never asserts done, TIMEOUT_CYCLES=20 -> timeout_o=1 and req_done_strb_o pulse 21 cycles after start; late mul_done in IDLE ignored; pending req1 then granted.
6. Reset while BUSY -> next cycle all outputs zero, no done pulse; fresh request afterwards completes normally.

Source files
------------

// File: rtl/mul_acc_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mul_acc_arbiter_pkg
// Shared definitions for the two-requester multiply-accumulate arbiter:
// FSM state encoding, requester count and default parameter values.
// -----------------------------------------------------------------------------
package mul_acc_arbiter_pkg;

  localparam int NUM_REQ                = 2;
  localparam int DEFAULT_N              = 41;
  localparam int DEFAULT_TIMEOUT_CYCLES = 4095;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mul_acc_arbiter_rr_arbiter_2.sv
// -----------------------------------------------------------------------------
// rr_arbiter_2
// Two-way round-robin grant for the shared multiplier.
//   clk_i, rst_i   clock and synchronous active-high reset
//   pending        per-requester pending flags
//   grant_en       high when the owner is idle and may consume a grant
//   grant_valid    some requester is pending
//   grant_idx      index of the requester that wins this cycle
// -----------------------------------------------------------------------------
module rr_arbiter_2
  import mul_acc_arbiter_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] pending,
  input  logic               grant_en,
  output logic               grant_valid,
  output logic               grant_idx
);

  logic last_grant;

  // A lone pending requester always wins; a tie goes to the requester that
  // did not win the previous tie.
  always_comb begin
    grant_valid = |pending;
    if (&pending) begin
      grant_idx = ~last_grant;
    end else begin
      grant_idx = pending[1];
    end
  end

  // The pointer only moves on contested grants, so an uncontested request in
  // between two ties does not steal the next tie from the other requester.
  // Reset value 1 makes requester 0 win the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant <= 1'b1;
    end else if (grant_en && (&pending)) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/mul_acc_arbiter.sv
// -----------------------------------------------------------------------------
// mul_acc_arbiter
// Shares one sequential multiply-accumulate unit between two requester cores.
// Each requester strobes its operands in, waits for its own done pulse and
// reads a private held result, so accumulation chains stay independent.
//   clk_i, rst_i                  clock, synchronous active-high reset
//   req_start_strb_i[1:0]         per-requester start pulse
//   req{0,1}_{a,b,acc}_i          requester operands, sampled on start pulse
//   req_done_strb_o[1:0]          per-requester completion pulse
//   req{0,1}_out_o                per-requester held result a*b+acc
//   mul_start_strb_o              start pulse to the shared multiplier
//   mul_{a,b,acc}_o               registered operands to the multiplier
//   mul_done_strb_i, mul_out_i    multiplier completion and result
//   busy_o                        an operation is in flight
//   overrun_o                     sticky: start while that requester busy
//   timeout_o                     sticky: multiplier did not answer in time
// -----------------------------------------------------------------------------
module mul_acc_arbiter
  import mul_acc_arbiter_pkg::*;
#(
  parameter int N              = DEFAULT_N,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [1:0]         req_start_strb_i,
  input  logic [2*N-1:0]     req0_a_i,
  input  logic [2*N-1:0]     req0_b_i,
  input  logic [2*N-1:0]     req0_acc_i,
  input  logic [2*N-1:0]     req1_a_i,
  input  logic [2*N-1:0]     req1_b_i,
  input  logic [2*N-1:0]     req1_acc_i,
  output logic [1:0]         req_done_strb_o,
  output logic [2*N-1:0]     req0_out_o,
  output logic [2*N-1:0]     req1_out_o,
  output logic               mul_start_strb_o,
  output logic [2*N-1:0]     mul_a_o,
  output logic [2*N-1:0]     mul_b_o,
  output logic [2*N-1:0]     mul_acc_o,
  input  logic               mul_done_strb_i,
  input  logic [2*N-1:0]     mul_out_i,
  output logic               busy_o,
  output logic               overrun_o,
  output logic               timeout_o
);

  localparam int W  = 2 * N;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);

  arb_state_e         state;
  logic               owner;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] in_flight;
  logic [NUM_REQ-1:0] accept;
  logic [NUM_REQ-1:0] grant_clear;
  logic [CW-1:0]      tmo_cnt;
  logic               op_done;
  logic               op_tmo;
  logic               grant_en;
  logic               grant_fire;
  logic               grant_valid;
  logic               grant_idx;

  logic [W-1:0] in_a     [NUM_REQ];
  logic [W-1:0] in_b     [NUM_REQ];
  logic [W-1:0] in_acc   [NUM_REQ];
  logic [W-1:0] hold_a   [NUM_REQ];
  logic [W-1:0] hold_b   [NUM_REQ];
  logic [W-1:0] hold_acc [NUM_REQ];

  assign in_a[0]   = req0_a_i;
  assign in_b[0]   = req0_b_i;
  assign in_acc[0] = req0_acc_i;
  assign in_a[1]   = req1_a_i;
  assign in_b[1]   = req1_b_i;
  assign in_acc[1] = req1_acc_i;

  // An operation that finishes this cycle (answer or timeout) no longer
  // counts as in flight, so its owner may already strobe the next request.
  always_comb begin
    op_done    = (state == ST_BUSY) && mul_done_strb_i;
    op_tmo     = (state == ST_BUSY) && !mul_done_strb_i && (tmo_cnt == TIMEOUT_VAL);
    grant_en   = (state == ST_IDLE);
    grant_fire = grant_en && grant_valid;
    for (int k = 0; k < NUM_REQ; k++) begin
      in_flight[k]   = (state == ST_BUSY) && (owner == 1'(k)) && !(op_done || op_tmo);
      accept[k]      = req_start_strb_i[k] && !pending[k] && !in_flight[k];
      grant_clear[k] = grant_fire && (grant_idx == 1'(k));
    end
  end

  rr_arbiter_2 u_rr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pending     (pending),
    .grant_en    (grant_en),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Holding registers only load on an accepted start, so a rejected
  // (overrun) pulse cannot corrupt operands still waiting for a grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        hold_a[k]   <= '0;
        hold_b[k]   <= '0;
        hold_acc[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (accept[k]) begin
          hold_a[k]   <= in_a[k];
          hold_b[k]   <= in_b[k];
          hold_acc[k] <= in_acc[k];
        end
      end
    end
  end

  // Control FSM: IDLE launches the arbitration winner onto the multiplier,
  // BUSY waits for the answer or the timeout and then routes the result
  // to the owner's private output register only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= ST_IDLE;
      owner            <= 1'b0;
      pending          <= '0;
      tmo_cnt          <= '0;
      req_done_strb_o  <= '0;
      req0_out_o       <= '0;
      req1_out_o       <= '0;
      mul_start_strb_o <= 1'b0;
      mul_a_o          <= '0;
      mul_b_o          <= '0;
      mul_acc_o        <= '0;
      busy_o           <= 1'b0;
      overrun_o        <= 1'b0;
      timeout_o        <= 1'b0;
    end else begin
      req_done_strb_o  <= '0;
      mul_start_strb_o <= 1'b0;
      pending          <= (pending & ~grant_clear) | accept;
      if (|(req_start_strb_i & ~accept)) begin
        overrun_o <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            mul_a_o          <= hold_a[grant_idx];
            mul_b_o          <= hold_b[grant_idx];
            mul_acc_o        <= hold_acc[grant_idx];
            mul_start_strb_o <= 1'b1;
            owner            <= grant_idx;
            busy_o           <= 1'b1;
            tmo_cnt          <= '0;
            state            <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (op_done) begin
            if (owner) begin
              req1_out_o <= mul_out_i;
            end else begin
              req0_out_o <= mul_out_i;
            end
            req_done_strb_o[owner] <= 1'b1;
            busy_o                 <= 1'b0;
            state                  <= ST_IDLE;
          end else if (op_tmo) begin
            timeout_o              <= 1'b1;
            req_done_strb_o[owner] <= 1'b1;
            busy_o                 <= 1'b0;
            state                  <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
